// File: rtl/div_unit_param_if.sv
// Issue and writeback handshake bundle for the iterative divider.
// The producer/consumer side uses master; the divider uses slave.
interface div_unit_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 3
);
  logic                  issue_new_request;
  logic [ID_WIDTH-1:0]   issue_id;
  logic [DATA_WIDTH-1:0] rs1;
  logic [DATA_WIDTH-1:0] rs2;
  logic [1:0]            op;
  logic                  reuse_result;
  logic                  issue_ready;
  logic                  wb_done;
  logic [DATA_WIDTH-1:0] wb_rd;
  logic [ID_WIDTH-1:0]   wb_id;
  logic                  wb_ack;

  modport master (
    output issue_new_request, issue_id, rs1, rs2, op, reuse_result, wb_ack,
    input  issue_ready, wb_done, wb_rd, wb_id
  );

  modport slave (
    input  issue_new_request, issue_id, rs1, rs2, op, reuse_result, wb_ack,
    output issue_ready, wb_done, wb_rd, wb_id
  );
endinterface

// File: rtl/div_unit_param.sv
// Radix-2 restoring divider (DIV/DIVU/REM/REMU) with an in-order input queue.
// Sign handling happens at issue; the core only ever divides magnitudes.
module div_unit_param #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int ID_WIDTH   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gc_fetch_flush,
  div_unit_param_if.slave  bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int NW = $clog2(DATA_WIDTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dvd;
    logic [DATA_WIDTH-1:0] dvs;
    logic                  rem;
    logic                  neg_q;
    logic                  neg_r;
    logic                  reuse;
    logic [ID_WIDTH-1:0]   id;
  } entry_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;

  // issue-side sign extraction and magnitude conversion
  logic   sgn, s1, s2;
  entry_t in_e;
  always_comb begin
    sgn         = ~bus.op[0];
    s1          = sgn & bus.rs1[DATA_WIDTH-1];
    s2          = sgn & bus.rs2[DATA_WIDTH-1];
    in_e.dvd    = s1 ? -bus.rs1 : bus.rs1;
    in_e.dvs    = s2 ? -bus.rs2 : bus.rs2;
    in_e.rem    = bus.op[1];
    in_e.neg_q  = s1 ^ s2;
    in_e.neg_r  = s1;
    in_e.reuse  = bus.reuse_result;
    in_e.id     = bus.issue_id;
  end

  // input queue
  entry_t          mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty, push, pop;
  entry_t          head;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full            = (count == CW'(FIFO_DEPTH));
  assign empty           = (count == '0);
  assign push            = bus.issue_new_request & ~full & ~gc_fetch_flush;
  assign head            = mem[rd_ptr];
  assign bus.issue_ready = ~full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_e;
  end

  always_ff @(posedge clk) begin
    if (rst || gc_fetch_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // control FSM
  logic [NW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || gc_fetch_flush) state_q <= IDLE;
    else                       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = (head.reuse || head.dvs == '0) ? DONE : BUSY;
      end
      BUSY: if (cnt == '0) state_d = DONE;
      DONE: if (bus.wb_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath: working registers are separate from the retained results so an
  // aborted division never disturbs what a later reuse op will read
  logic [DATA_WIDTH-1:0] wq, wr, dvs_q, q_res, r_res;
  logic [DATA_WIDTH:0]   rem_sh, diff;
  logic                  cur_rem, cur_nq, cur_nr, cur_zero;
  logic [ID_WIDTH-1:0]   cur_id;
  logic [DATA_WIDTH-1:0] q_nxt, r_nxt;

  always_comb begin
    rem_sh = {wr, wq[DATA_WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    q_nxt  = {wq[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
    r_nxt  = diff[DATA_WIDTH] ? rem_sh[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      wq       <= '0;
      wr       <= '0;
      dvs_q    <= '0;
      q_res    <= '0;
      r_res    <= '0;
      cur_rem  <= 1'b0;
      cur_nq   <= 1'b0;
      cur_nr   <= 1'b0;
      cur_zero <= 1'b0;
      cur_id   <= '0;
    end else if (gc_fetch_flush) begin
      cnt <= '0;
    end else begin
      if (pop) begin
        cur_rem  <= head.rem;
        cur_nq   <= head.neg_q;
        cur_nr   <= head.neg_r;
        cur_zero <= (head.dvs == '0);
        cur_id   <= head.id;
        cnt      <= NW'(DATA_WIDTH - 1);
        wq       <= head.dvd;
        wr       <= '0;
        dvs_q    <= head.dvs;
        if (head.dvs == '0) begin
          q_res <= '1;
          r_res <= head.dvd;
        end
      end
      if (state_q == BUSY) begin
        wq  <= q_nxt;
        wr  <= r_nxt;
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          q_res <= q_nxt;
          r_res <= r_nxt;
        end
      end
    end
  end

  // divide-by-zero quotient stays all ones regardless of operand signs
  assign bus.wb_done = (state_q == DONE);
  assign bus.wb_id   = cur_id;
  assign bus.wb_rd   = cur_rem ? (cur_nr ? -r_res : r_res)
                               : ((cur_nq & ~cur_zero) ? -q_res : q_res);
endmodule

// File: doc/div_unit_param.md
DIV_UNIT_PARAM -- requirements
Module: div_unit_param

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand/result width in bits, >= 8.
REQ-002 Parameter FIFO_DEPTH, default 2: input queue entries, power of two, >= 1.
REQ-003 Parameter ID_WIDTH, default 3: instruction id width.
REQ-004 clk  input  1  clock; everything sampled on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 gc_fetch_flush  input  1  abort all queued and in-progress operations.
REQ-007 issue_new_request  input  1  push operation this cycle.
REQ-008 issue_id  input  ID_WIDTH  id of pushed operation.
REQ-009 rs1  input  DATA_WIDTH  dividend.
REQ-010 rs2  input  DATA_WIDTH  divisor.
REQ-011 op  input  2  op[0]=1 unsigned, op[1]=1 remainder (00 DIV, 01 DIVU, 10 REM, 11 REMU).
REQ-012 reuse_result  input  1  operands equal to the previous computed division; skip iteration.
REQ-013 issue_ready  output  1  queue can accept a push.
REQ-014 wb_done  output  1  result valid.
REQ-015 wb_rd  output  DATA_WIDTH  result.
REQ-016 wb_id  output  ID_WIDTH  id of result.
REQ-017 wb_ack  input  1  consumer accepts result; only meaningful while wb_done=1.

Function
REQ-018 Signed ops (op[0]=0): operands converted to magnitudes; quotient negated when sign bits differ; remainder negated when rs1 negative; unsigned ops use operands unchanged.
REQ-019 Sign determination and magnitude conversion done before enqueue; queue entry = magnitudes, remainder flag, negate_quotient, negate_remainder, reuse flag, id.
REQ-020 Queue is FIFO_DEPTH-entry in-order FIFO; issue_ready = not full (registered-path, no pop bypass); push while full is ignored and is a protocol error.
REQ-021 FSM states IDLE, BUSY, DONE; reset and flush state = IDLE.
REQ-022 IDLE, queue non-empty: pop head; if reuse flag or divisor magnitude = 0 go DONE next cycle, else go BUSY with iteration counter = DATA_WIDTH-1.
REQ-023 BUSY: one restoring radix-2 iteration per cycle (shift remainder left, bring in next dividend bit MSB-first, subtract divisor if no borrow, shift quotient bit in); counter decrements; after DATA_WIDTH iterations go DONE.
REQ-024 Latency: pop in cycle T -> wb_done first high in cycle T+DATA_WIDTH+1; reuse or zero divisor -> T+1.
REQ-025 DONE: wb_done=1 and wb_rd/wb_id held stable until wb_ack; on wb_ack go IDLE; next pop no earlier than following cycle.
REQ-026 Unsigned quotient and remainder registers retained after completion and used unchanged by reuse ops, with new op's remainder flag and negate flags applied.
REQ-027 Divisor zero: quotient result = all ones, never negated; remainder result = rs1 (magnitude re-negated by negate_remainder).
REQ-028 Overflow (signed most-negative / -1): quotient = most-negative value, remainder = 0, produced by normal magnitude path with no special case.
REQ-029 Negation is two's complement modulo 2^DATA_WIDTH.
REQ-030 wb_id = id of popped operation; results return strictly in issue order.
REQ-031 gc_fetch_flush: next cycle queue empty, FSM IDLE, wb_done=0, counter cleared; retained quotient/remainder unchanged; a push coincident with flush is dropped.
REQ-032 Push and pop in same cycle allowed when not full; occupancy unchanged.

Reset
REQ-033 rst takes priority over all inputs including gc_fetch_flush.
REQ-034 After reset: wb_done=0, wb_rd=0, wb_id=0, issue_ready=1, queue empty, FSM IDLE, retained quotient/remainder=0.
REQ-035 Reset mid-BUSY or DONE discards operation; no wb_done afterwards for it.

Verification
REQ-036 DATA_WIDTH=32, DIV rs1=0xFFFFFFF9 (-7), rs2=2, popped T -> wb_done at T+33, wb_rd=0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-037 DIVU 100/0 -> wb_rd=0xFFFFFFFF at T+1; REM rs1=0x80000005, rs2=0 -> 0x80000005 at T+1.
REQ-038 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0x00000000.
REQ-039 DIVU 17/5 -> 3 at T+33, then REMU with reuse_result=1 -> 2 at T+1 after its pop.
REQ-040 FIFO_DEPTH=2: push ids 1,2,3 back-to-back while BUSY -> issue_ready low after two queued, results return ids 1,2,3 in order, wb_ack held low 5 cycles keeps wb_rd stable.
REQ-041 gc_fetch_flush at BUSY cycle 10 with one queued op -> wb_done never rises for either, issue_ready=1 next cycle, new DIVU 9/3 returns 3 at normal latency.
